// File: rtl/compressed_line_unpacker.sv
// Holds one packed compressed line and presents a left-aligned window at a running bit offset
// to the word decoder. It advances the offset by each returned codeword length and flags line done or error.
module compressed_line_unpacker #(
    parameter int CACHE_LINE     = 128,
    parameter int WORD_SIZE      = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_line_valid,
    output logic                  o_line_ready,
    input  logic [CACHE_LINE-1:0] i_line_data,
    input  logic [7:0]            i_line_bits,
    output logic [WORD_SIZE-1:0]  o_window,
    output logic                  o_window_valid,
    input  logic                  i_consume_valid,
    input  logic [6:0]            i_consume_len,
    output logic [7:0]            o_offset,
    output logic [2:0]            o_word_count,
    output logic                  o_done_flag,
    output logic                  o_error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DONE
    } state_t;

    localparam logic [8:0] LINE_MAX  = 9'(CACHE_LINE);
    localparam logic [6:0] LEN_MAX   = 7'(WORD_SIZE);
    localparam logic [2:0] WORDS_MAX = 3'(WORDS_PER_LINE);

    state_t                state;
    logic [CACHE_LINE-1:0] line_q;
    logic [7:0]            bits_q;

    logic                  bits_bad;
    logic                  len_bad;
    logic                  overrun;
    logic [8:0]            new_off;
    logic [2:0]            count_inc;
    logic [WORD_SIZE-1:0]  window_raw;

    // Zero-padding below the line makes bits read past its end come out as zero.
    assign window_raw = WORD_SIZE'(({line_q, {WORD_SIZE{1'b0}}} << o_offset) >> CACHE_LINE);
    assign o_window   = o_window_valid ? window_raw : '0;

    // The 9-bit sum keeps offset + length from wrapping before the overrun compare.
    assign new_off   = {1'b0, o_offset} + {2'b00, i_consume_len};
    assign count_inc = o_word_count + 3'd1;
    assign bits_bad  = (i_line_bits == 8'd0) || ({1'b0, i_line_bits} > LINE_MAX);
    assign len_bad   = (i_consume_len == 7'd0) || (i_consume_len > LEN_MAX);
    assign overrun   = new_off > {1'b0, bits_q};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state          <= S_IDLE;
            line_q         <= '0;
            bits_q         <= '0;
            o_offset       <= '0;
            o_word_count   <= '0;
            o_line_ready   <= 1'b1;
            o_window_valid <= 1'b0;
            o_done_flag    <= 1'b0;
            o_error        <= 1'b0;
        end else begin
            o_done_flag <= 1'b0;
            o_error     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_line_valid) begin
                        line_q       <= i_line_data;
                        bits_q       <= i_line_bits;
                        o_offset     <= '0;
                        o_word_count <= '0;
                        if (bits_bad) begin
                            o_error <= 1'b1;
                        end else begin
                            state          <= S_ACTIVE;
                            o_line_ready   <= 1'b0;
                            o_window_valid <= 1'b1;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (i_consume_valid) begin
                        // A bad length or an overrun abandons the line, leaving offset and count as they were.
                        if (len_bad || overrun) begin
                            o_error        <= 1'b1;
                            state          <= S_IDLE;
                            o_line_ready   <= 1'b1;
                            o_window_valid <= 1'b0;
                        end else begin
                            o_offset     <= new_off[7:0];
                            o_word_count <= count_inc;
                            if (count_inc == WORDS_MAX) begin
                                state          <= S_DONE;
                                o_window_valid <= 1'b0;
                                o_done_flag    <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state        <= S_IDLE;
                    o_line_ready <= 1'b1;
                end
                default: begin
                    state          <= S_IDLE;
                    o_line_ready   <= 1'b1;
                    o_window_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_compressed_line_unpacker.sv
// Directed and randomized bench for compressed_line_unpacker, checked every cycle
// against a bit-level reference model of the line decoding rules.
module tb_compressed_line_unpacker;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_line_valid;
    logic         o_line_ready;
    logic [127:0] i_line_data;
    logic [7:0]   i_line_bits;
    logic [63:0]  o_window;
    logic         o_window_valid;
    logic         i_consume_valid;
    logic [6:0]   i_consume_len;
    logic [7:0]   o_offset;
    logic [2:0]   o_word_count;
    logic         o_done_flag;
    logic         o_error;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 idle, 1 decoding a line, 2 line finished
    int           m_phase;
    logic [127:0] m_line;
    int           m_bits;
    int           m_off;
    int           m_cnt;
    logic         m_done;
    logic         m_err;

    compressed_line_unpacker dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_line_valid    (i_line_valid),
        .o_line_ready    (o_line_ready),
        .i_line_data     (i_line_data),
        .i_line_bits     (i_line_bits),
        .o_window        (o_window),
        .o_window_valid  (o_window_valid),
        .i_consume_valid (i_consume_valid),
        .i_consume_len   (i_consume_len),
        .o_offset        (o_offset),
        .o_word_count    (o_word_count),
        .o_done_flag     (o_done_flag),
        .o_error         (o_error)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [63:0] modelWindow(input logic [127:0] line, input int off);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 64; i++) begin
            if (off + i < 128) w[63-i] = line[127-(off+i)];
        end
        return w;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_phase = 0;
        m_line  = '0;
        m_bits  = 0;
        m_off   = 0;
        m_cnt   = 0;
        m_done  = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic modelEdge();
        int len;
        len    = int'(i_consume_len);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (m_phase == 0) begin
            if (i_line_valid) begin
                m_line = i_line_data;
                m_bits = int'(i_line_bits);
                m_off  = 0;
                m_cnt  = 0;
                if (m_bits == 0 || m_bits > 128) m_err = 1'b1;
                else m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (i_consume_valid) begin
                if (len == 0 || len > 64 || m_off + len > m_bits) begin
                    m_err   = 1'b1;
                    m_phase = 0;
                end else begin
                    m_off = m_off + len;
                    m_cnt = m_cnt + 1;
                    if (m_cnt == 4) begin
                        m_phase = 2;
                        m_done  = 1'b1;
                    end
                end
            end
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic checkAll();
        checkOutput("window", o_window, (m_phase == 1) ? modelWindow(m_line, m_off) : 64'd0);
        checkOutput("window_valid", 64'(o_window_valid), 64'(m_phase == 1));
        checkOutput("line_ready", 64'(o_line_ready), 64'(m_phase == 0));
        checkOutput("offset", 64'(o_offset), 64'(m_off));
        checkOutput("word_count", 64'(o_word_count), 64'(m_cnt));
        checkOutput("done_flag", 64'(o_done_flag), 64'(m_done));
        checkOutput("error", 64'(o_error), 64'(m_err));
    endtask

    // Drives one cycle of inputs, advances the model at the edge and checks the outputs just after it.
    task automatic applyStimulus(input logic lv, input logic [127:0] data, input logic [7:0] bits,
                                 input logic cv, input logic [6:0] len);
        i_line_valid    = lv;
        i_line_data     = data;
        i_line_bits     = bits;
        i_consume_valid = cv;
        i_consume_len   = len;
        @(posedge i_clk);
        modelEdge();
        #1;
        checkAll();
    endtask

    task automatic pulseReset();
        #2 i_reset = 1'b1;
        #1;
        modelReset();
        checkAll();
        checkOutput("reset_ready", 64'(o_line_ready), 64'd1);
        #2 i_reset = 1'b0;
    endtask

    task automatic feedLine(input logic [127:0] data, input logic [7:0] bits);
        applyStimulus(1'b1, data, bits, 1'b0, 7'd0);
    endtask

    task automatic consume(input logic [6:0] len);
        applyStimulus(1'b0, '0, 8'd0, 1'b1, len);
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 8'd0, 1'b0, 7'd0);
    endtask

    initial begin
        logic [127:0] line;
        logic [63:0]  low_half;
        logic         lv;
        logic         cv;
        logic [7:0]   bits;
        logic [6:0]   len;
        int           r;

        i_reset         = 1'b1;
        i_line_valid    = 1'b0;
        i_line_data     = '0;
        i_line_bits     = '0;
        i_consume_valid = 1'b0;
        i_consume_len   = '0;
        modelReset();
        #3;
        checkAll();
        #4 i_reset = 1'b0;

        $display("[TB] T1 short line, four 8-bit codewords");
        line = 128'hA5 << 120;
        feedLine(line, 8'd32);
        checkOutput("t1_first_window", o_window, 64'hA500_0000_0000_0000);
        for (int i = 0; i < 4; i++) consume(7'd8);
        checkOutput("t1_done", 64'(o_done_flag), 64'd1);
        checkOutput("t1_offset", 64'(o_offset), 64'd32);
        idle();
        checkOutput("t1_ready_after", 64'(o_line_ready), 64'd1);

        $display("[TB] T2 full line, lengths 64 32 16 16");
        line = {$urandom, $urandom, $urandom, $urandom};
        low_half = line[63:0];
        feedLine(line, 8'd128);
        consume(7'd64);
        checkOutput("t2_window_at_64", o_window, low_half);
        consume(7'd32);
        consume(7'd16);
        consume(7'd16);
        checkOutput("t2_offset", 64'(o_offset), 64'd128);
        checkOutput("t2_done", 64'(o_done_flag), 64'd1);
        idle();

        $display("[TB] T3 overrun");
        feedLine({$urandom, $urandom, $urandom, $urandom}, 8'd20);
        consume(7'd16);
        consume(7'd8);
        checkOutput("t3_error", 64'(o_error), 64'd1);
        checkOutput("t3_offset", 64'(o_offset), 64'd16);
        idle();

        $display("[TB] T4 illegal line lengths");
        feedLine({$urandom, $urandom, $urandom, $urandom}, 8'd0);
        checkOutput("t4_error_zero", 64'(o_error), 64'd1);
        idle();
        feedLine({$urandom, $urandom, $urandom, $urandom}, 8'd129);
        checkOutput("t4_error_129", 64'(o_error), 64'd1);
        checkOutput("t4_ready", 64'(o_line_ready), 64'd1);
        idle();

        $display("[TB] T5 illegal codeword lengths");
        feedLine({$urandom, $urandom, $urandom, $urandom}, 8'd128);
        consume(7'd0);
        checkOutput("t5_error_len0", 64'(o_error), 64'd1);
        feedLine({$urandom, $urandom, $urandom, $urandom}, 8'd128);
        consume(7'd64);
        consume(7'd65);
        checkOutput("t5_error_len65", 64'(o_error), 64'd1);
        checkOutput("t5_offset_kept", 64'(o_offset), 64'd64);
        feedLine({$urandom, $urandom, $urandom, $urandom}, 8'd128);
        consume(7'd64);
        consume(7'd64);
        checkOutput("t5_offset_128", 64'(o_offset), 64'd128);
        checkOutput("t5_window_zero", o_window, 64'd0);
        consume(7'd1);
        idle();

        $display("[TB] T6 reset mid-line");
        feedLine({$urandom, $urandom, $urandom, $urandom}, 8'd128);
        consume(7'd8);
        consume(7'd8);
        pulseReset();
        line = {$urandom, $urandom, $urandom, $urandom};
        feedLine(line, 8'd64);
        for (int i = 0; i < 4; i++) consume(7'd16);
        checkOutput("t6_done", 64'(o_done_flag), 64'd1);
        idle();

        $display("[TB] randomized traffic");
        for (int n = 0; n < 2000; n++) begin
            lv = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 19);
            if (r == 0) bits = 8'd0;
            else if (r == 1) bits = 8'($urandom_range(129, 255));
            else if (r < 8) bits = 8'($urandom_range(1, 128));
            else bits = 8'($urandom_range(96, 128));
            cv = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 39);
            if (r == 0) len = 7'd0;
            else if (r == 1) len = 7'($urandom_range(65, 127));
            else if (r < 6) len = 7'($urandom_range(1, 64));
            else len = 7'($urandom_range(1, 32));
            applyStimulus(lv, {$urandom, $urandom, $urandom, $urandom}, bits, cv, len);
            if ($urandom_range(0, 299) == 0) pulseReset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
